add_s_acc: RTL and testbench

- Multi-channel signed saturating accumulator with registered output; the clocked successor to the team's combinational saturating adder.
- Each of NCH channels holds a WIDTH-bit signed running sum. A valid input sample is added to the selected channel with overflow/underflow protection, in saturating or wrapping mode.
- Per-channel sticky OF/UF flags are kept for status readout.
- Sits between sample producers (filters, counters) and the status/CSR logic.

---
 rtl/add_s_pkg.sv | 35 +++
 rtl/add_s_core.sv | 25 ++
 rtl/add_s_acc.sv | 99 +++++++++
 tb/tb_add_s_acc.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/add_s_pkg.sv
// Shared arithmetic for the saturating adder family: limits and a sign-aware add.
// Values are carried sign-extended in a wide container; callers keep the low WIDTH bits.
package add_s_pkg;

    localparam int MAXW = 64;

    typedef logic signed [MAXW-1:0] wide_t;

    typedef struct packed {
        logic  of;
        logic  uf;
        wide_t sum;
    } add_res_t;

    function automatic wide_t poslim(input int w);
        return (wide_t'(1) << (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t neglim(input int w);
        return -(wide_t'(1) << (w - 1));
    endfunction

    // Inputs must already be sign-extended from w bits, so the wide sum never wraps.
    function automatic add_res_t sat_add(input wide_t a, input wide_t b, input int w,
                                         input logic sat_en);
        add_res_t r;
        r.sum = a + b;
        r.of  = (r.sum > poslim(w));
        r.uf  = (r.sum < neglim(w));
        if (sat_en && r.of) r.sum = poslim(w);
        if (sat_en && r.uf) r.sum = neglim(w);
        return r;
    endfunction

endpackage

// File: rtl/add_s_core.sv
// Combinational WIDTH-bit signed adder with overflow/underflow detection.
// SAT_EN=1 clamps to the signed limits; SAT_EN=0 wraps but still flags.
module add_s_core
    import add_s_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             of_o,
    output logic             uf_o
);

    add_res_t res;
    logic     unused_hi;

    assign res       = sat_add(wide_t'($signed(a_i)), wide_t'($signed(b_i)), WIDTH, SAT_EN);
    assign sum_o     = res.sum[WIDTH-1:0];
    assign of_o      = res.of;
    assign uf_o      = res.uf;
    assign unused_hi = ^res.sum[MAXW-1:WIDTH];

endmodule

// File: rtl/add_s_acc.sv
// Multi-channel signed accumulator: per-channel running sums, a one-cycle result
// register and per-channel sticky overflow/underflow status.
module add_s_acc
    import add_s_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NCH    = 4,
    parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CHW-1:0]   in_ch,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_load,
    input  logic [NCH-1:0]   flag_clr,
    output logic             out_valid,
    output logic [CHW-1:0]   out_ch,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_of,
    output logic             out_uf,
    output logic [NCH-1:0]   sticky_of,
    output logic [NCH-1:0]   sticky_uf
);

    localparam logic [CHW:0] NCH_W = (CHW + 1)'(NCH);

    logic [WIDTH-1:0] acc_q [NCH];
    logic             out_valid_q;
    logic [CHW-1:0]   out_ch_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_of_q, out_uf_q;
    logic [NCH-1:0]   sticky_of_q, sticky_of_d;
    logic [NCH-1:0]   sticky_uf_q, sticky_uf_d;

    logic             accept;
    logic [WIDTH-1:0] acc_sel;
    logic [WIDTH-1:0] sum;
    logic             of, uf;
    logic [NCH-1:0]   ch_hot;

    // Out-of-range channels (NCH not a power of two) are dropped without side effects.
    assign accept  = in_valid && !rst && ({1'b0, in_ch} < NCH_W);
    assign acc_sel = in_load ? '0 : acc_q[in_ch];

    add_s_core #(.WIDTH(WIDTH), .SAT_EN(SAT_EN)) u_core (
        .a_i   (acc_sel),
        .b_i   (in_data),
        .sum_o (sum),
        .of_o  (of),
        .uf_o  (uf)
    );

    always_comb begin
        // NOTE: default first so every path assigns ch_hot and no latch is inferred.
        ch_hot = '0;
        if (accept) ch_hot[in_ch] = 1'b1;
    end

    // A new event on a channel wins over a clear arriving in the same cycle.
    assign sticky_of_d = (sticky_of_q & ~flag_clr) | (ch_hot & {NCH{of}});
    assign sticky_uf_d = (sticky_uf_q & ~flag_clr) | (ch_hot & {NCH{uf}});

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the channel array is reset too, since a cleared sum is part of the reset state.
            for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_sum_q   <= '0;
            out_of_q    <= 1'b0;
            out_uf_q    <= 1'b0;
            sticky_of_q <= '0;
            sticky_uf_q <= '0;
        end else begin
            // NOTE: non-blocking so a back-to-back sample reads this cycle's sum next cycle.
            out_valid_q <= accept;
            if (accept) begin
                acc_q[in_ch] <= sum;
                out_ch_q     <= in_ch;
                out_sum_q    <= sum;
                out_of_q     <= of;
                out_uf_q     <= uf;
            end
            sticky_of_q <= sticky_of_d;
            sticky_uf_q <= sticky_uf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_sum   = out_sum_q;
    assign out_of    = out_of_q;
    assign out_uf    = out_uf_q;
    assign sticky_of = sticky_of_q;
    assign sticky_uf = sticky_uf_q;

endmodule

// File: tb/tb_add_s_acc.sv
// Directed bench for add_s_acc at WIDTH=4: a saturating and a wrapping instance share
// stimulus, and a three-channel instance covers the out-of-range channel index.
module tb_add_s_acc;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_load;
    logic [1:0] in_ch;
    logic [3:0] in_data, flag_clr;

    logic       s_valid, s_of, s_uf;
    logic [1:0] s_ch;
    logic [3:0] s_sum, s_sof, s_suf;

    logic       w_valid, w_of, w_uf;
    logic [1:0] w_ch;
    logic [3:0] w_sum, w_sof, w_suf;

    logic       t_valid, t_of, t_uf;
    logic [1:0] t_ch;
    logic [3:0] t_sum;
    logic [2:0] t_sof, t_suf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    add_s_acc #(.WIDTH(4), .NCH(4), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .in_load(in_load), .flag_clr(flag_clr), .out_valid(s_valid), .out_ch(s_ch),
        .out_sum(s_sum), .out_of(s_of), .out_uf(s_uf), .sticky_of(s_sof), .sticky_uf(s_suf)
    );

    add_s_acc #(.WIDTH(4), .NCH(4), .SAT_EN(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .in_load(in_load), .flag_clr(flag_clr), .out_valid(w_valid), .out_ch(w_ch),
        .out_sum(w_sum), .out_of(w_of), .out_uf(w_uf), .sticky_of(w_sof), .sticky_uf(w_suf)
    );

    add_s_acc #(.WIDTH(4), .NCH(3), .SAT_EN(1'b1)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .in_load(in_load), .flag_clr(flag_clr[2:0]), .out_valid(t_valid), .out_ch(t_ch),
        .out_sum(t_sum), .out_of(t_of), .out_uf(t_uf), .sticky_of(t_sof), .sticky_uf(t_suf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [3:0] d,
                         input logic ld);
        in_valid = v;
        in_ch    = ch;
        in_data  = d;
        in_load  = ld;
    endtask

    initial begin
        rst = 1'b1;
        flag_clr = '0;
        drive(1'b0, 2'd0, 4'h0, 1'b0);
        step();
        rst = 1'b0;
        check("rst_valid", 32'(s_valid), 0);
        check("rst_sum",   32'(s_sum),   0);
        check("rst_ch",    32'(s_ch),    0);
        check("rst_flags", 32'({s_of, s_uf}), 0);
        check("rst_sticky", 32'({s_sof, s_suf}), 0);

        repeat (3) step();
        check("idle_valid", 32'(s_valid), 0);
        check("idle_sum",   32'(s_sum),   0);

        // Sample presented during reset must be ignored.
        rst = 1'b1;
        drive(1'b1, 2'd1, 4'd5, 1'b0);
        step();
        rst = 1'b0;
        check("rst_in_valid", 32'(s_valid), 0);

        drive(1'b1, 2'd1, 4'd3, 1'b0); step();
        check("acc1_valid", 32'(s_valid), 1);
        check("acc1_ch",    32'(s_ch),    1);
        check("acc1_sum",   32'(s_sum),   3);
        drive(1'b1, 2'd1, 4'd2, 1'b0); step();
        check("acc2_sum",   32'(s_sum),   5);
        drive(1'b1, 2'd1, 4'd1, 1'b0); step();
        check("acc3_sum",   32'(s_sum),   6);
        check("acc3_flags", 32'({s_of, s_uf}), 0);

        // 6 + 3 = 9: clamps to 7 saturating, wraps to -7 (4'h9) wrapping.
        drive(1'b1, 2'd1, 4'd3, 1'b0); step();
        check("of_sum",     32'(s_sum), 7);
        check("of_flag",    32'(s_of),  1);
        check("of_sticky",  32'(s_sof), 4'b0010);
        check("wrap_sum",   32'(w_sum), 4'h9);
        check("wrap_of",    32'(w_of),  1);

        drive(1'b1, 2'd1, 4'd0, 1'b0); step();
        check("hold7_sum",    32'(s_sum), 7);
        check("hold7_of",     32'(s_of),  0);
        check("hold7_sticky", 32'(s_sof), 4'b0010);

        // Load -7 then add -4: -11 clamps to -8 (4'h8), wraps to 5.
        drive(1'b1, 2'd2, 4'h9, 1'b1); step();
        check("load_sum",   32'(s_sum), 4'h9);
        check("load_flags", 32'({s_of, s_uf}), 0);
        drive(1'b1, 2'd2, 4'hC, 1'b0); step();
        check("uf_sum",     32'(s_sum), 4'h8);
        check("uf_flag",    32'(s_uf),  1);
        check("uf_sticky",  32'(s_suf), 4'b0100);
        check("wrapuf_sum", 32'(w_sum), 5);
        check("wrapuf_uf",  32'(w_uf),  1);
        drive(1'b1, 2'd2, 4'd5, 1'b1); step();
        check("load5_sum",    32'(s_sum), 5);
        check("load5_flags",  32'({s_of, s_uf}), 0);
        check("load5_sticky", 32'(s_suf), 4'b0100);

        // Interleaved independent channels 0 and 3.
        drive(1'b1, 2'd0, 4'd2, 1'b0); step();
        check("ch0_a", 32'({s_ch, s_sum}), {2'd0, 4'd2});
        drive(1'b1, 2'd3, 4'hD, 1'b0); step();
        check("ch3_a", 32'({s_ch, s_sum}), {2'd3, 4'hD});
        drive(1'b1, 2'd0, 4'd4, 1'b0); step();
        check("ch0_b", 32'({s_ch, s_sum}), {2'd0, 4'd6});
        drive(1'b1, 2'd3, 4'hF, 1'b0); step();
        check("ch3_b", 32'({s_ch, s_sum}), {2'd3, 4'hC});

        // Clear racing a new overflow on ch1: the event wins.
        flag_clr = 4'b0010;
        drive(1'b1, 2'd1, 4'd1, 1'b0); step();
        check("race_of",     32'(s_of),  1);
        check("race_sticky", 32'(s_sof), 4'b0010);
        drive(1'b0, 2'd0, 4'd0, 1'b0); step();
        check("clr_valid",   32'(s_valid), 0);
        check("clr_sticky",  32'(s_sof), 4'b0000);
        check("clr_other",   32'(s_suf), 4'b0100);
        check("clr_holdsum", 32'(s_sum), 7);
        flag_clr = 4'b0000;

        // Channel 3 is out of range for the three-channel instance.
        drive(1'b1, 2'd3, 4'd1, 1'b0); step();
        check("ch3_c",       32'(s_sum),   4'hD);
        check("oor_valid",   32'(t_valid), 0);

        flag_clr = 4'b0100;
        drive(1'b0, 2'd0, 4'd0, 1'b0); step();
        check("clr_uf", 32'(s_suf), 0);
        flag_clr = 4'b0000;

        // Mid-stream reset discards the sample and clears every channel.
        rst = 1'b1;
        drive(1'b1, 2'd0, 4'd1, 1'b0); step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(s_valid), 0);
        check("mid_rst_sum",   32'(s_sum),   0);
        check("mid_rst_stky",  32'({s_sof, s_suf}), 0);
        step();
        check("post_rst_sum",  32'(s_sum), 1);
        drive(1'b1, 2'd3, 4'd2, 1'b0); step();
        check("post_rst_ch3",  32'(s_sum), 2);
        drive(1'b0, 2'd0, 4'd0, 1'b0); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
